// File: rtl/lens_shading_bayer_pkg.sv
// Shared pixel-stream data types and DI terminal selects used by the lens shading corrector.
// No ports: constants only.
package lens_shading_bayer_pkg;

    localparam int unsigned DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'h8;
    // Any data type with this bit set carries a pixel.
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'h8;

    localparam logic [15:0] TERM_VignetteCol = 16'h0031;
    localparam logic [15:0] TERM_VignetteRow = 16'h0032;

endpackage

// File: rtl/lens_shading_bayer_gain_interp_axis.sv
// One axis (row or column) of the shading gain: per-channel subsampled gain
// tables with a DI write/read port, and a registered linear interpolation of
// the table at the current position.
// Ports:
//   di_clk, resetb_clk      clock, async active-low reset (gain only; tables not reset)
//   pos, ch                 current position on this axis and Bayer channel
//   wr_en, acc_ch, acc_entry, wr_data   DI table write (out-of-range entries dropped)
//   rd_data_c               combinational DI read data (0 when out of range)
//   gain                    registered interpolated gain
module gain_interp_axis #(
    parameter int unsigned NUM_CHANNELS    = 4,
    parameter int unsigned DIM_WIDTH       = 11,
    parameter int unsigned GAIN_WIDTH      = 10,
    parameter int unsigned SUBSAMPLE_SHIFT = 4,
    parameter int unsigned SUB_N           = 81,
    parameter int unsigned CH_W            = 2
) (
    input  logic                  di_clk,
    input  logic                  resetb_clk,
    input  logic [DIM_WIDTH-1:0]  pos,
    input  logic [CH_W-1:0]       ch,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       acc_ch,
    input  logic [DIM_WIDTH-1:0]  acc_entry,
    input  logic [GAIN_WIDTH-1:0] wr_data,
    output logic [GAIN_WIDTH-1:0] rd_data_c,
    output logic [GAIN_WIDTH-1:0] gain
);

    localparam int unsigned IDX_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
    localparam int unsigned PW    = GAIN_WIDTH + SUBSAMPLE_SHIFT + 2;

    logic [GAIN_WIDTH-1:0] tbl [NUM_CHANNELS][SUB_N];

    logic                       acc_in_range;
    logic [DIM_WIDTH-1:0]       i0_raw;
    logic [IDX_W-1:0]           i0;
    logic [IDX_W-1:0]           i1;
    logic [SUBSAMPLE_SHIFT-1:0] frac;
    logic [GAIN_WIDTH-1:0]      y0;
    logic [GAIN_WIDTH-1:0]      y1;
    logic signed [GAIN_WIDTH:0] diff;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       delta;
    logic signed [PW-1:0]       sum;

    assign acc_in_range = (32'(acc_entry) < SUB_N);
    assign rd_data_c    = acc_in_range ? tbl[acc_ch][IDX_W'(acc_entry)] : '0;

    // DI table write; entries beyond the table are silently dropped.
    always_ff @(posedge di_clk) begin
        if (wr_en && acc_in_range) begin
            tbl[acc_ch][IDX_W'(acc_entry)] <= wr_data;
        end
    end

    // Neighbouring table points, clamped to the last entry past the table end.
    always_comb begin
        i0_raw = pos >> SUBSAMPLE_SHIFT;
        frac   = pos[SUBSAMPLE_SHIFT-1:0];
        if (32'(i0_raw) >= SUB_N) begin
            i0 = IDX_W'(SUB_N - 1);
            i1 = IDX_W'(SUB_N - 1);
        end else begin
            i0 = IDX_W'(i0_raw);
            i1 = ((32'(i0_raw) + 32'd1) < SUB_N) ? IDX_W'(32'(i0_raw) + 32'd1) : IDX_W'(i0_raw);
        end
        y0 = tbl[ch][i0];
        y1 = tbl[ch][i1];
        // Signed slope with floor shift keeps the result between y0 and y1.
        diff  = $signed({1'b0, y1}) - $signed({1'b0, y0});
        prod  = PW'(diff) * $signed(PW'({1'b0, frac}));
        delta = prod >>> SUBSAMPLE_SHIFT;
        sum   = $signed(PW'({1'b0, y0})) + delta;
    end

    always_ff @(posedge di_clk or negedge resetb_clk) begin
        if (!resetb_clk) begin
            gain <= '0;
        end else begin
            gain <= GAIN_WIDTH'(sum);
        end
    end

endmodule

// File: rtl/lens_shading_bayer.sv
// Lens shading / vignette corrector for a Bayer (or mono) pixel stream.
// Each pixel is scaled by an interpolated column gain times an interpolated row
// gain, chosen per Bayer channel, with saturation. Fixed 3-cycle latency on all beats.
// Ports:
//   di_clk, resetb_clk        clock, async active-low reset
//   enable, bayer_phase       correction enable, channel-0 column/row parity
//   di_*                      DI bus table access (TERM_VignetteCol / TERM_VignetteRow)
//   dvi, dtypei, datai        input stream
//   dvo, dtypeo, datao        output stream (input delayed 3 cycles, pixels corrected)
module lens_shading_bayer
    import lens_shading_bayer_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH     = 10,
    parameter int unsigned DI_DATA_WIDTH   = 32,
    parameter int unsigned DIM_WIDTH       = 11,
    parameter int unsigned NUM_ROWS        = 728,
    parameter int unsigned NUM_COLS        = 1286,
    parameter int unsigned NUM_CHANNELS    = 4,
    parameter int unsigned GAIN_WIDTH      = 10,
    parameter int unsigned GAIN_FRAC_WIDTH = 8,
    parameter int unsigned SUBSAMPLE_SHIFT = 4
) (
    input  logic                     di_clk,
    input  logic                     resetb_clk,
    input  logic                     enable,
    input  logic [1:0]               bayer_phase,
    input  logic [15:0]              di_term_addr,
    input  logic [31:0]              di_reg_addr,
    input  logic                     di_read_mode,
    input  logic                     di_read_req,
    input  logic                     di_read,
    input  logic                     di_write_mode,
    input  logic                     di_write,
    input  logic [DI_DATA_WIDTH-1:0] di_reg_datai,
    output logic                     di_read_rdy,
    output logic [DI_DATA_WIDTH-1:0] di_reg_datao,
    output logic                     di_write_rdy,
    output logic [15:0]              di_transfer_status,
    output logic                     di_en,
    input  logic                     dvi,
    input  logic [DTYPE_WIDTH-1:0]   dtypei,
    input  logic [15:0]              datai,
    output logic                     dvo,
    output logic [DTYPE_WIDTH-1:0]   dtypeo,
    output logic [15:0]              datao
);

    localparam int unsigned SUB_NUM_COLS = (NUM_COLS + (1 << SUBSAMPLE_SHIFT) - 1) >> SUBSAMPLE_SHIFT;
    localparam int unsigned SUB_NUM_ROWS = (NUM_ROWS + (1 << SUBSAMPLE_SHIFT) - 1) >> SUBSAMPLE_SHIFT;
    localparam int unsigned CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned P1_W         = PIXEL_WIDTH + GAIN_WIDTH;
    localparam int unsigned P2_W         = P1_W + GAIN_WIDTH;

    logic                   col_term;
    logic                   row_term;
    logic                   is_pixel;
    logic [CH_W-1:0]        pix_ch;
    logic [CH_W-1:0]        acc_ch;
    logic [DIM_WIDTH-1:0]   row_pos;
    logic [DIM_WIDTH-1:0]   col_pos;
    logic [GAIN_WIDTH-1:0]  cg;
    logic [GAIN_WIDTH-1:0]  rg;
    logic [GAIN_WIDTH-1:0]  col_rd_c;
    logic [GAIN_WIDTH-1:0]  row_rd_c;

    logic                   s1_dv, s2_dv;
    logic [DTYPE_WIDTH-1:0] s1_dtype, s2_dtype;
    logic [15:0]            s1_data, s2_data;
    logic                   s1_corr, s2_corr;
    logic [GAIN_WIDTH-1:0]  s2_rg;
    logic [P1_W-1:0]        s2_p1;
    logic [P2_W-1:0]        p2;
    logic                   p2_ovf;
    logic [PIXEL_WIDTH-1:0] res;

    logic unused_ok;
    assign unused_ok = &{1'b0, di_read_mode, di_read_req, di_write_mode,
                         di_reg_addr[31:DIM_WIDTH+2], di_reg_datai[DI_DATA_WIDTH-1:GAIN_WIDTH]};

    assign di_read_rdy        = 1'b1;
    assign di_write_rdy       = 1'b1;
    assign di_transfer_status = 16'h0000;

    assign col_term = (di_term_addr == TERM_VignetteCol);
    assign row_term = (di_term_addr == TERM_VignetteRow);
    assign di_en    = col_term | row_term;
    assign is_pixel = |(dtypei & DTYPE_PIXEL_MASK);

    assign pix_ch = (NUM_CHANNELS == 1) ? '0 :
                    CH_W'({row_pos[0] ^ bayer_phase[1], col_pos[0] ^ bayer_phase[0]});
    assign acc_ch = (NUM_CHANNELS == 1) ? '0 : CH_W'(di_reg_addr[DIM_WIDTH+1:DIM_WIDTH]);

    // Frame position; counters saturate and run regardless of enable.
    always_ff @(posedge di_clk or negedge resetb_clk) begin
        if (!resetb_clk) begin
            row_pos <= '0;
            col_pos <= '0;
        end else if (dvi) begin
            if (dtypei == DTYPE_FRAME_START) begin
                row_pos <= '0;
            end else if ((dtypei == DTYPE_ROW_END) && (row_pos != '1)) begin
                row_pos <= row_pos + DIM_WIDTH'(1);
            end
            if (dtypei == DTYPE_ROW_START) begin
                col_pos <= '0;
            end else if (is_pixel && (col_pos != '1)) begin
                col_pos <= col_pos + DIM_WIDTH'(1);
            end
        end
    end

    gain_interp_axis #(
        .NUM_CHANNELS(NUM_CHANNELS), .DIM_WIDTH(DIM_WIDTH), .GAIN_WIDTH(GAIN_WIDTH),
        .SUBSAMPLE_SHIFT(SUBSAMPLE_SHIFT), .SUB_N(SUB_NUM_COLS), .CH_W(CH_W)
    ) u_col_axis (
        .di_clk(di_clk), .resetb_clk(resetb_clk), .pos(col_pos), .ch(pix_ch),
        .wr_en(di_write & col_term), .acc_ch(acc_ch), .acc_entry(di_reg_addr[DIM_WIDTH-1:0]),
        .wr_data(di_reg_datai[GAIN_WIDTH-1:0]), .rd_data_c(col_rd_c), .gain(cg)
    );

    gain_interp_axis #(
        .NUM_CHANNELS(NUM_CHANNELS), .DIM_WIDTH(DIM_WIDTH), .GAIN_WIDTH(GAIN_WIDTH),
        .SUBSAMPLE_SHIFT(SUBSAMPLE_SHIFT), .SUB_N(SUB_NUM_ROWS), .CH_W(CH_W)
    ) u_row_axis (
        .di_clk(di_clk), .resetb_clk(resetb_clk), .pos(row_pos), .ch(pix_ch),
        .wr_en(di_write & row_term), .acc_ch(acc_ch), .acc_entry(di_reg_addr[DIM_WIDTH-1:0]),
        .wr_data(di_reg_datai[GAIN_WIDTH-1:0]), .rd_data_c(row_rd_c), .gain(rg)
    );

    // DI readback, registered; holds when no read is addressed here.
    always_ff @(posedge di_clk or negedge resetb_clk) begin
        if (!resetb_clk) begin
            di_reg_datao <= '0;
        end else if (di_en && di_read) begin
            di_reg_datao <= DI_DATA_WIDTH'(col_term ? col_rd_c : row_rd_c);
        end
    end

    // Final product and saturation to the pixel range.
    always_comb begin
        p2     = P2_W'(s2_rg) * P2_W'(s2_p1);
        p2_ovf = |(p2 >> (2 * GAIN_FRAC_WIDTH + PIXEL_WIDTH));
        res    = p2_ovf ? '1 : PIXEL_WIDTH'(p2 >> (2 * GAIN_FRAC_WIDTH));
    end

    // Three-stage pipeline; S1 gains live in the axis instances.
    always_ff @(posedge di_clk or negedge resetb_clk) begin
        if (!resetb_clk) begin
            s1_dv    <= 1'b0;
            s1_dtype <= '0;
            s1_data  <= '0;
            s1_corr  <= 1'b0;
            s2_dv    <= 1'b0;
            s2_dtype <= '0;
            s2_data  <= '0;
            s2_corr  <= 1'b0;
            s2_rg    <= '0;
            s2_p1    <= '0;
            dvo      <= 1'b0;
            dtypeo   <= '0;
            datao    <= '0;
        end else begin
            s1_dv    <= dvi;
            s1_dtype <= dtypei;
            s1_data  <= datai;
            s1_corr  <= enable & dvi & is_pixel;
            s2_dv    <= s1_dv;
            s2_dtype <= s1_dtype;
            s2_data  <= s1_data;
            s2_corr  <= s1_corr;
            s2_rg    <= rg;
            s2_p1    <= P1_W'(cg) * P1_W'(s1_data[PIXEL_WIDTH-1:0]);
            dvo      <= s2_dv;
            dtypeo   <= s2_dtype;
            datao    <= s2_corr ? 16'(res) : s2_data;
        end
    end

endmodule

// File: tb/tb_lens_shading_bayer.sv
// Scoreboard bench for lens_shading_bayer: stimulus pushes expected output beats,
// a negedge monitor pops and compares whenever dvo is high.
module tb_lens_shading_bayer;
    import lens_shading_bayer_pkg::*;

    localparam int unsigned DIMW = 11;

    logic             di_clk;
    logic             resetb_clk;
    logic             enable;
    logic [1:0]       bayer_phase;
    logic [15:0]      di_term_addr;
    logic [31:0]      di_reg_addr;
    logic             di_read_mode, di_read_req, di_read, di_write_mode, di_write;
    logic [31:0]      di_reg_datai;
    logic             di_read_rdy;
    logic [31:0]      di_reg_datao;
    logic             di_write_rdy;
    logic [15:0]      di_transfer_status;
    logic             di_en;
    logic             dvi;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic [15:0]      datai;
    logic             dvo;
    logic [DTYPE_WIDTH-1:0] dtypeo;
    logic [15:0]      datao;

    lens_shading_bayer #(
        .PIXEL_WIDTH(10), .DI_DATA_WIDTH(32), .DIM_WIDTH(DIMW), .NUM_ROWS(8), .NUM_COLS(16),
        .NUM_CHANNELS(4), .GAIN_WIDTH(11), .GAIN_FRAC_WIDTH(8), .SUBSAMPLE_SHIFT(2)
    ) dut (
        .di_clk(di_clk), .resetb_clk(resetb_clk), .enable(enable), .bayer_phase(bayer_phase),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_read_mode(di_read_mode),
        .di_read_req(di_read_req), .di_read(di_read), .di_write_mode(di_write_mode),
        .di_write(di_write), .di_reg_datai(di_reg_datai), .di_read_rdy(di_read_rdy),
        .di_reg_datao(di_reg_datao), .di_write_rdy(di_write_rdy),
        .di_transfer_status(di_transfer_status), .di_en(di_en), .dvi(dvi), .dtypei(dtypei),
        .datai(datai), .dvo(dvo), .dtypeo(dtypeo), .datao(datao)
    );

    initial di_clk = 1'b0;
    always #5 di_clk = ~di_clk;

    int cyc = 0;
    always @(posedge di_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DTYPE_WIDTH-1:0] dtype;
        logic [15:0]            data;
        int                     cyc;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every output beat must match the oldest expected beat, 3 cycles after issue.
    always @(negedge di_clk) begin
        if (resetb_clk && dvo) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_dvo: got datao 0x%0h expected no beat", datao);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("datao", longint'(datao), longint'(e.data));
                check("dtypeo", longint'(dtypeo), longint'(e.dtype));
                check("latency", longint'(cyc - e.cyc), 64'd3);
            end
        end
    end

    task automatic tick();
        @(posedge di_clk);
        #1;
    endtask

    task automatic beat(input logic dv, input logic [DTYPE_WIDTH-1:0] dt,
                        input logic [15:0] d, input logic [15:0] e);
        dvi    = dv;
        dtypei = dt;
        datai  = d;
        if (dv) sb.push_back('{dt, e, cyc});
        tick();
        dvi    = 1'b0;
        dtypei = '0;
        datai  = 16'h0000;
    endtask

    task automatic pix(input logic [15:0] d, input logic [15:0] e);
        beat(1'b1, DTYPE_PIXEL, d, e);
    endtask

    task automatic ctl(input logic [DTYPE_WIDTH-1:0] dt, input logic [15:0] d);
        beat(1'b1, dt, d, d);
    endtask

    task automatic di_wr(input logic [15:0] term, input int ch, input int ent, input logic [31:0] val);
        di_term_addr  = term;
        di_reg_addr   = (32'(ch) << DIMW) | 32'(ent);
        di_reg_datai  = val;
        di_write      = 1'b1;
        di_write_mode = 1'b1;
        tick();
        di_write      = 1'b0;
        di_write_mode = 1'b0;
        di_term_addr  = 16'h0000;
    endtask

    task automatic di_rd_chk(input string name, input logic [15:0] term, input int ch,
                             input int ent, input logic [31:0] exp);
        di_term_addr = term;
        di_reg_addr  = (32'(ch) << DIMW) | 32'(ent);
        di_read      = 1'b1;
        di_read_mode = 1'b1;
        di_read_req  = 1'b1;
        tick();
        di_read      = 1'b0;
        di_read_mode = 1'b0;
        di_read_req  = 1'b0;
        di_term_addr = 16'h0000;
        check(name, longint'(di_reg_datao), longint'(exp));
    endtask

    // Same value in every entry, per channel.
    task automatic fill(input logic [15:0] term, input int n_ent,
                        input int g0, input int g1, input int g2, input int g3);
        for (int e = 0; e < n_ent; e++) begin
            di_wr(term, 0, e, 32'(g0));
            di_wr(term, 1, e, 32'(g1));
            di_wr(term, 2, e, 32'(g2));
            di_wr(term, 3, e, 32'(g3));
        end
    endtask

    task automatic set_all_ch(input logic [15:0] term, input int ent, input int val);
        for (int c = 0; c < 4; c++) di_wr(term, c, ent, 32'(val));
    endtask

    logic [15:0] exp_col [18] = '{16'd100, 16'd125, 16'd150, 16'd175, 16'd200, 16'd200,
                                  16'd200, 16'd200, 16'd200, 16'd225, 16'd250, 16'd275,
                                  16'd300, 16'd300, 16'd300, 16'd300, 16'd300, 16'd300};
    logic [15:0] exp_row [9]  = '{16'd200, 16'd174, 16'd149, 16'd124, 16'd99,
                                  16'd99, 16'd99, 16'd99, 16'd99};

    initial begin
        resetb_clk    = 1'b0;
        enable        = 1'b1;
        bayer_phase   = 2'b00;
        di_term_addr  = 16'h0000;
        di_reg_addr   = 32'h0;
        di_read_mode  = 1'b0;
        di_read_req   = 1'b0;
        di_read       = 1'b0;
        di_write_mode = 1'b0;
        di_write      = 1'b0;
        di_reg_datai  = 32'h0;
        dvi           = 1'b0;
        dtypei        = '0;
        datai         = 16'h0000;

        #2;
        check("reset_dvo", longint'(dvo), 64'd0);
        check("reset_dtypeo", longint'(dtypeo), 64'd0);
        check("reset_datao", longint'(datao), 64'd0);
        check("reset_di_reg_datao", longint'(di_reg_datao), 64'd0);
        check("di_read_rdy", longint'(di_read_rdy), 64'd1);
        check("di_write_rdy", longint'(di_write_rdy), 64'd1);
        check("di_transfer_status", longint'(di_transfer_status), 64'd0);
        tick();
        resetb_clk = 1'b1;

        di_term_addr = TERM_VignetteRow;
        #1 check("di_en_row", longint'(di_en), 64'd1);
        di_term_addr = 16'h0007;
        #1 check("di_en_other", longint'(di_en), 64'd0);
        di_term_addr = 16'h0000;
        tick();

        // Unity gains: pixels and sideband pass with value intact.
        fill(TERM_VignetteCol, 4, 256, 256, 256, 256);
        fill(TERM_VignetteRow, 2, 256, 256, 256, 256);
        ctl(DTYPE_FRAME_START, 16'h0F00);
        ctl(DTYPE_ROW_START, 16'h1234);
        pix(16'd500, 16'd500);
        beat(1'b0, DTYPE_PIXEL, 16'h5555, 16'h0000);
        pix(16'd1023, 16'd1023);
        ctl(DTYPE_ROW_END, 16'h00AA);

        // Column interpolation, including positions past the table end.
        set_all_ch(TERM_VignetteCol, 0, 256);
        set_all_ch(TERM_VignetteCol, 1, 512);
        set_all_ch(TERM_VignetteCol, 2, 512);
        set_all_ch(TERM_VignetteCol, 3, 768);
        ctl(DTYPE_FRAME_START, 16'h0000);
        ctl(DTYPE_ROW_START, 16'h0000);
        for (int c = 0; c < 18; c++) pix(16'd100, exp_col[c]);

        // Row interpolation with a falling slope (floor rounding) and row clamp.
        fill(TERM_VignetteCol, 4, 256, 256, 256, 256);
        set_all_ch(TERM_VignetteRow, 0, 512);
        set_all_ch(TERM_VignetteRow, 1, 255);
        ctl(DTYPE_FRAME_START, 16'h0001);
        for (int r = 0; r < 9; r++) begin
            ctl(DTYPE_ROW_START, 16'h0002);
            pix(16'd100, exp_row[r]);
            ctl(DTYPE_ROW_END, 16'h0003);
        end

        // Saturation at the pixel range, upper datai bits ignored on pixels.
        fill(TERM_VignetteCol, 4, 512, 512, 512, 512);
        fill(TERM_VignetteRow, 2, 512, 512, 512, 512);
        ctl(DTYPE_FRAME_START, 16'h0000);
        ctl(DTYPE_ROW_START, 16'h0000);
        pix(16'd300, 16'd1023);
        pix(16'd200, 16'd800);
        pix(16'hF0C8, 16'd800);
        pix(16'd256, 16'd1023);
        pix(16'd255, 16'd1020);

        // Bayer channel select by phase.
        fill(TERM_VignetteCol, 4, 256, 512, 768, 1024);
        fill(TERM_VignetteRow, 2, 256, 256, 256, 256);
        ctl(DTYPE_FRAME_START, 16'h0000);
        ctl(DTYPE_ROW_START, 16'h0000);
        pix(16'd100, 16'd100);
        pix(16'd100, 16'd200);
        pix(16'd100, 16'd100);
        pix(16'd100, 16'd200);
        ctl(DTYPE_ROW_END, 16'h0000);
        ctl(DTYPE_ROW_START, 16'h0000);
        pix(16'd100, 16'd300);
        pix(16'd100, 16'd400);
        bayer_phase = 2'b01;
        ctl(DTYPE_FRAME_START, 16'h0000);
        ctl(DTYPE_ROW_START, 16'h0000);
        pix(16'd100, 16'd200);
        pix(16'd100, 16'd100);
        bayer_phase = 2'b10;
        ctl(DTYPE_FRAME_START, 16'h0000);
        ctl(DTYPE_ROW_START, 16'h0000);
        pix(16'd100, 16'd300);
        pix(16'd100, 16'd400);
        bayer_phase = 2'b00;
        for (int i = 0; i < 5; i++) tick();

        // DI readback and out-of-range accesses.
        di_wr(TERM_VignetteCol, 2, 2, 32'hFFFF_0155);
        di_rd_chk("rd_col_ch2_e2", TERM_VignetteCol, 2, 2, 32'h155);
        di_wr(TERM_VignetteCol, 1, 5, 32'h2AA);
        di_rd_chk("rd_col_oor", TERM_VignetteCol, 1, 5, 32'h0);
        di_rd_chk("rd_col_ch1_e1", TERM_VignetteCol, 1, 1, 32'd512);
        di_rd_chk("rd_row_ch3_e1", TERM_VignetteRow, 3, 1, 32'd256);
        di_wr(TERM_VignetteRow, 0, 2, 32'h3FF);
        di_rd_chk("rd_row_oor", TERM_VignetteRow, 0, 2, 32'h0);
        di_rd_chk("rd_row_ch0_e0", TERM_VignetteRow, 0, 0, 32'd256);
        di_rd_chk("rd_col_ch3_e3", TERM_VignetteCol, 3, 3, 32'd1024);
        di_rd_chk("rd_other_term_holds", 16'h0007, 3, 0, 32'd1024);

        // Asynchronous reset with beats in flight.
        ctl(DTYPE_FRAME_START, 16'h0000);
        ctl(DTYPE_ROW_START, 16'h0000);
        pix(16'd100, 16'd100);
        pix(16'd100, 16'd200);
        pix(16'd100, 16'd100);
        pix(16'd100, 16'd200);
        resetb_clk = 1'b0;
        #1;
        check("midreset_dvo", longint'(dvo), 64'd0);
        check("midreset_datao", longint'(datao), 64'd0);
        check("midreset_dtypeo", longint'(dtypeo), 64'd0);
        check("midreset_di_reg_datao", longint'(di_reg_datao), 64'd0);
        sb.delete();
        tick();
        resetb_clk = 1'b1;

        // Counters restart at row 0 / col 0 without a frame start.
        pix(16'd100, 16'd100);
        pix(16'd100, 16'd200);
        // Pass-through when disabled; enable takes effect per beat.
        enable = 1'b0;
        pix(16'hF0C8, 16'hF0C8);
        pix(16'd300, 16'd300);
        enable = 1'b1;
        pix(16'd100, 16'd100);
        pix(16'd100, 16'd200);
        enable = 1'b0;
        ctl(DTYPE_FRAME_END, 16'hBEEF);
        enable = 1'b1;

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d beats outstanding expected 0", sb.size());
        end
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
